// File: rtl/intr_hub_arbiter_if.sv
// ============================================================================
// Module  : intr_hub_arbiter_if
// Purpose : Interrupt hub bus between the edge-detect/controller side and the
//           pending-latch arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface intr_hub_arbiter_if #(
  parameter int NUM_INTR = 8,
  parameter int ID_WIDTH = 3
);
  logic [NUM_INTR-1:0] int_pulse;
  logic [NUM_INTR-1:0] int_mask;
  logic                irq_ack;
  logic [NUM_INTR-1:0] ovf_clr;
  logic                irq_req;
  logic [ID_WIDTH-1:0] irq_id;
  logic [NUM_INTR-1:0] pending;
  logic [NUM_INTR-1:0] overflow;

  modport master (
    output int_pulse,
    output int_mask,
    output irq_ack,
    output ovf_clr,
    input  irq_req,
    input  irq_id,
    input  pending,
    input  overflow
  );

  modport slave (
    input  int_pulse,
    input  int_mask,
    input  irq_ack,
    input  ovf_clr,
    output irq_req,
    output irq_id,
    output pending,
    output overflow
  );
endinterface

`default_nettype wire

// File: rtl/intr_hub_arbiter.sv
// ============================================================================
// Module  : intr_hub_arbiter
// Purpose : Latches interrupt pulses as pending bits, picks the lowest-index
//           unmasked source and holds a request/ID pair until acknowledged.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_hub_arbiter #(
  parameter int NUM_INTR = 8,
  parameter int ID_WIDTH = 3,
  parameter int HOLDOFF  = 4
) (
  input  logic              clk,
  input  logic              rst,
  intr_hub_arbiter_if.slave bus
);

  localparam logic [7:0]          c_holdoff = 8'(HOLDOFF);
  localparam logic [NUM_INTR-1:0] c_one     = NUM_INTR'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  logic [7:0]          r_hold_cnt;
  logic                r_irq_req;
  logic [ID_WIDTH-1:0] r_irq_id;
  logic [NUM_INTR-1:0] r_pending;
  logic [NUM_INTR-1:0] r_overflow;

  logic [NUM_INTR-1:0] w_eligible;
  logic [ID_WIDTH-1:0] w_winner;
  logic                w_ack_accept;
  logic [NUM_INTR-1:0] w_clr;
  logic [NUM_INTR-1:0] w_ovf_set;

  assign w_eligible   = r_pending & bus.int_mask;
  assign w_ack_accept = (r_state == S_REQ) && bus.irq_ack;
  assign w_clr        = w_ack_accept ? (c_one << r_irq_id) : '0;
  // A pulse landing on a bit that is being acked this cycle re-arms it cleanly.
  assign w_ovf_set    = bus.int_pulse & r_pending & ~w_clr;

  // Fixed priority: scanning downward lets the lowest index overwrite last.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_INTR - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = ID_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_clr) | bus.int_pulse;
      r_overflow <= (r_overflow & ~bus.ovf_clr) | w_ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_irq_req  <= 1'b0;
      r_irq_id   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_eligible) begin
            r_irq_id  <= w_winner;
            r_irq_req <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.irq_ack) begin
            r_irq_req <= 1'b0;
            if (c_holdoff == 8'd0) begin
              r_state <= S_IDLE;
            end else begin
              r_hold_cnt <= c_holdoff;
              r_state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          r_hold_cnt <= r_hold_cnt - 8'd1;
          if (r_hold_cnt <= 8'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_irq_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_req  = r_irq_req;
  assign bus.irq_id   = r_irq_id;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: doc/intr_hub_arbiter.md
Name: intr_hub_arbiter

Overview:
Collects the one-cycle interrupt pulses produced by the per-source edge-detect stages and latches them as pending bits. It masks the pending bits and picks one winner by fixed priority, then presents it to the host-side interrupt controller as a request/ID pair. The request is held until the controller acknowledges it. The block sits directly downstream of the NUM_INTR edge-detect instances inside the KC705 interrupt hub.

Parameters:
NUM_INTR, 8, number of interrupt sources (1..32)
ID_WIDTH, 3, width of irq_id; must satisfy 2**ID_WIDTH >= NUM_INTR
HOLDOFF, 4, idle cycles enforced after each acknowledge before the next request (0..255)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  synchronous, active-high reset
int_pulse  in  NUM_INTR  one-cycle pulses from the edge-detect stages; bit i = source i
int_mask  in  NUM_INTR  1 = source enabled for arbitration
irq_ack  in  1  controller acknowledge for the currently presented irq_id
ovf_clr  in  NUM_INTR  write-1-to-clear for overflow bits
irq_req  out  1  request to controller, level, held until acked
irq_id  out  ID_WIDTH  index of the requesting source, stable while irq_req=1
pending  out  NUM_INTR  latched, unserviced interrupts (unmasked view)
overflow  out  NUM_INTR  sticky: pulse arrived while the same source was already pending

Behaviour:
- Reset (rst=1 at posedge): irq_req=0, irq_id=0, pending=0, overflow=0, FSM=IDLE, holdoff counter=0.
- Reset mid-operation clears everything immediately. Outstanding requests and pending bits are discarded, and no ack is expected afterwards.
- pending[i] set:
  - At a posedge where int_pulse[i]=1, regardless of int_mask[i].
  - Cleared only by an accepted ack with irq_id=i.
  - Set and clear in the same cycle: set wins, and pending[i] stays 1.
- overflow[i] set:
  - When int_pulse[i]=1 while pending[i]=1 and pending[i] is not being cleared that cycle.
  - Cleared by ovf_clr[i]=1. Set and clear in the same cycle: set wins.
- Eligible vector = pending & int_mask. Winner = lowest index with an eligible bit.
- FSM states:
  - IDLE:
    - If eligible != 0: register irq_id=winner, irq_req=1, go REQ.
    - Else stay.
  - REQ:
    - irq_req=1 and irq_id frozen.
    - Masking the active source or new higher-priority pulses do NOT withdraw or change the request.
    - irq_ack=1: clear pending[irq_id], irq_req=0 at the next posedge.
    - After the ack, go HOLD with counter=HOLDOFF, or IDLE if HOLDOFF=0.
  - HOLD:
    - irq_req=0. Counter decrements each cycle.
    - At counter==1, go IDLE. HOLD therefore lasts exactly HOLDOFF cycles.
- irq_ack in IDLE or HOLD is ignored and has no side effects.
- Latency, HOLDOFF idle and the source enabled:
  - int_pulse sampled at posedge T gives pending=1 after T.
  - irq_req=1 after T+1, so the request appears 2 cycles after the pulse.
- Back-to-back servicing:
  - Ack sampled at posedge A gives irq_req=0 after A.
  - The next request is registered at posedge A+HOLDOFF+1 and is visible after it.
- irq_id upper bits beyond the source index are 0. Source indices >= NUM_INTR never appear.

Test Plan:
1. Reset, mask=8'hFF, pulse bit 5 at cycle 10 -> pending=8'h20 after cycle 10. irq_req=1 with irq_id=5 after cycle 11. Ack at cycle 14 -> irq_req=0 and pending=0 after cycle 14.
2. Pulses on bits 6, 2 and 0 in the same cycle, HOLDOFF=4 -> three requests in order with irq_id 0, 2, 6. Each starts exactly 5 cycles after the previous ack. Pending shrinks 8'h45 -> 8'h44 -> 8'h40 -> 0.
3. Bit 3 pulsed twice while pending, before the ack -> overflow=8'h08 and only one request. ovf_clr=8'h08 concurrent with a third pulse -> overflow stays 8'h08. ovf_clr alone next cycle -> overflow=0.
4. mask=8'h00, pulse bit 1 -> pending=8'h02 and irq_req stays 0. Set mask bit 1 -> irq_req=1 with irq_id=1 one cycle later. Clear mask while in REQ -> request held until ack.
5. irq_id=4 in REQ. Pulse bit 4 in the same cycle as the ack -> pending[4] stays 1 and overflow[4]=0. After HOLDOFF, request re-issued with irq_id=4.
6. rst=1 asserted while in REQ with pending=8'h81 -> next cycle all outputs 0. A stray irq_ack after reset causes no change. HOLDOFF=0 build: ack -> next request issued on the following posedge.
